// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
// Bundle between the EX/MEM pipeline and the HI/LO multiply/divide unit.
//   master : pipeline side (drives op requests, flush, MFHI/MFLO reads)
//   slave  : hilo_muldiv_unit (reports busy/stall/done, exposes HI/LO)
// Signals:
//   start, op[2:0], a, b  : op request and its operands
//   flush                 : squash any in-flight op
//   rd_req, hilo_sel      : MFHI/MFLO in the memory stage, 1 = HI, 0 = LO
//   busy, stall_req, done : unit status towards the hazard unit / pipeline
//   hi, lo, hilo_mux_out  : architectural registers and MFxx read data
// ---------------------------------------------------------------------------
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             rd_req;
  logic             hilo_sel;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_mux_out;

  modport master (
    output start, op, a, b, flush, rd_req, hilo_sel,
    input  busy, stall_req, done, hi, lo, hilo_mux_out
  );

  modport slave (
    input  start, op, a, b, flush, rd_req, hilo_sel,
    output busy, stall_req, done, hi, lo, hilo_mux_out
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
// Multicycle multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU finish in one busy cycle; DIV/DIVU run a restoring divide on
// operand magnitudes (one quotient bit per cycle) followed by a sign-fix
// cycle. MTHI/MTLO write directly while idle.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low
//   bus   : hilo_muldiv_if.slave
//     start/op/a/b      op request (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO)
//     flush             abort in-flight op, ignore same-cycle start
//     rd_req/hilo_sel   MFHI/MFLO read request and HI/LO select
//     busy              mul/div in progress
//     stall_req         busy & (start | rd_req), combinational
//     done              one-cycle pulse while a freshly written result is shown
//     hi/lo             architectural registers
//     hilo_mux_out      hilo_sel ? hi : lo
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV     = 2'd2,
    DIV_FIX = 2'd3
  } state_t;

  // Full-width product; operands are sign- or zero-extended to 2*WIDTH so a
  // single multiplier serves both signed and unsigned forms.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    logic signed [2*WIDTH-1:0] prod;
    xe   = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye   = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    prod = xe * ye;
    return prod;
  endfunction

  // Magnitude of a possibly-signed operand. MIN_INT maps to itself, which is
  // the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  state_t           state_q, state_d;

  logic [WIDTH-1:0] opa_q;      // original a: multiplicand, or dividend for /0
  logic [WIDTH-1:0] opb_q;      // original b: multiplier
  logic             sgn_q;      // signed variant of the op
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend shifts out the top, quotient bits in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_mul_op;
  logic             is_div_op;
  logic             sgn_op;
  logic             accept;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             bit_ge;
  logic [2*WIDTH-1:0] product;

  assign is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign sgn_op    = (bus.op == OP_MULT) || (bus.op == OP_DIV);

  // New work is only taken while idle, and never in a flushed cycle.
  assign accept    = (state_q == IDLE) && bus.start && !bus.flush;

  // One restoring-divide step. shifted < 2*divisor, so bit WIDTH of trial is
  // set exactly when the subtraction would go negative.
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign bit_ge    = !trial[WIDTH];

  assign product   = mul_full(opa_q, opb_q, sgn_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && is_mul_op) begin
            state_d = MUL;
          end else if (bus.start && is_div_op) begin
            state_d = DIV;
          end
        end
        MUL:     state_d = IDLE;
        DIV:     if (cnt_q == '0) state_d = DIV_FIX;
        DIV_FIX: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa_q      <= '0;
      opb_q      <= '0;
      sgn_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (is_mul_op || is_div_op) begin
          opa_q      <= bus.a;
          opb_q      <= bus.b;
          sgn_q      <= sgn_op;
          rem_q      <= '0;
          quo_q      <= magnitude(bus.a, sgn_op);
          dvs_q      <= magnitude(bus.b, sgn_op);
          neg_quo_q  <= sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_q  <= sgn_op && bus.a[WIDTH-1];
          div_zero_q <= (bus.b == '0);
          cnt_q      <= CNT_W'(WIDTH - 1);
        end
        if (bus.op == OP_MTHI) hi_q <= bus.a;
        if (bus.op == OP_MTLO) lo_q <= bus.a;
      end else if (!bus.flush) begin
        unique case (state_q)
          MUL: begin
            {hi_q, lo_q} <= product;
            done_q       <= 1'b1;
          end
          DIV: begin
            rem_q <= bit_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], bit_ge};
            cnt_q <= cnt_q - CNT_W'(1);
          end
          DIV_FIX: begin
            // Divide by zero reports all-ones quotient and the raw dividend.
            if (div_zero_q) begin
              lo_q <= '1;
              hi_q <= opa_q;
            end else begin
              lo_q <= apply_sign(quo_q, neg_quo_q);
              hi_q <= apply_sign(rem_q, neg_rem_q);
            end
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.stall_req    = bus.busy && (bus.start || bus.rd_req);
  assign bus.done         = done_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.hilo_mux_out = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_muldiv_unit
// Directed bench for hilo_muldiv_unit. Each mul/div issued pushes its
// hand-computed {hi,lo} into a queue; a monitor pops and compares whenever
// done is presented. Control behaviour (busy length, stall, flush, reset)
// is checked inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [63:0] mon_e;
  string       mon_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: done=1 with nothing pending, hi=%h lo=%h", bus.hi, bus.lo);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, "_hi"}, 64'(bus.hi), 64'(mon_e[63:32]));
        check({mon_n, "_lo"}, 64'(bus.lo), 64'(mon_e[31:0]));
      end
    end
  end

  // Issue one mul/div, expect its result through the scoreboard and check
  // how many cycles busy stays high.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int exp_busy);
    int n;
    exp_q.push_back({ehi, elo});
    name_q.push_back(name);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start    = 1'b0;
    bus.op       = 3'd7;
    bus.a        = '0;
    bus.b        = '0;
    bus.flush    = 1'b0;
    bus.rd_req   = 1'b0;
    bus.hilo_sel = 1'b0;
    rst          = 1'b0;
    repeat (2) tick();

    check("reset_hi",    64'(bus.hi),        64'h0);
    check("reset_lo",    64'(bus.lo),        64'h0);
    check("reset_busy",  64'(bus.busy),      64'h0);
    check("reset_done",  64'(bus.done),      64'h0);
    check("reset_stall", 64'(bus.stall_req), 64'h0);
    rst = 1'b1;
    tick();

    // Multiplies: one busy cycle each
    run_op("mult_m2x3",   3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    run_op("multu_maxx2", 3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1);
    run_op("mult_m3xm5",  3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 1);
    run_op("multu_maxsq", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);

    // Divides: WIDTH+1 busy cycles each
    run_op("div_m7d2",    3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_7d2",    3'd3, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 33);
    run_op("div_7dm2",    3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("div_min_m1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_5d0",    3'd3, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 33);
    run_op("div_m9d0",    3'd2, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 33);
    run_op("divu_maxd16", 3'd3, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 33);

    // MTHI / MTLO back to back
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'h1234;
    tick();
    bus.op    = 3'd5;
    bus.a     = 32'h5678;
    tick();
    bus.start = 1'b0;
    check("mt_hi",   64'(bus.hi),   64'h1234);
    check("mt_lo",   64'(bus.lo),   64'h5678);
    check("mt_busy", 64'(bus.busy), 64'h0);
    bus.hilo_sel = 1'b1;
    #1 check("mux_sel_hi", 64'(bus.hilo_mux_out), 64'h1234);
    bus.hilo_sel = 1'b0;
    #1 check("mux_sel_lo", 64'(bus.hilo_mux_out), 64'h5678);

    // Stall while dividing, dropped second op, then flush
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("stall_busy_c10", 64'(bus.busy), 64'h1);
    bus.rd_req   = 1'b1;
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.a        = 32'd3;
    bus.b        = 32'd3;
    bus.hilo_sel = 1'b1;
    #1 check("stall_c10", 64'(bus.stall_req), 64'h1);
    check("mux_old_while_busy", 64'(bus.hilo_mux_out), 64'h1234);
    tick();
    check("stall_c11", 64'(bus.stall_req), 64'h1);
    bus.start  = 1'b0;
    bus.rd_req = 1'b0;
    bus.flush  = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'h0);
    check("flush_hi",   64'(bus.hi),   64'h1234);
    check("flush_lo",   64'(bus.lo),   64'h5678);
    tick();
    check("dropped_op_idle", 64'(bus.busy), 64'h0);

    // flush with a same-cycle MTHI: the write is ignored
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hDEAD;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_mthi_hi", 64'(bus.hi), 64'h1234);

    // flush on the MUL completion edge discards the product
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_mul_busy", 64'(bus.busy), 64'h0);
    check("flush_mul_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

    // ops 6-7 are no-ops
    bus.start = 1'b1;
    bus.op    = 3'd6;
    bus.a     = 32'hFFFF;
    tick();
    bus.start = 1'b0;
    check("noop_busy", 64'(bus.busy), 64'h0);
    check("noop_hilo", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

    // Asynchronous reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'hFFFF_FFF9;
    bus.b     = 32'd2;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #1 rst = 1'b0;
    #1;
    check("rst_mid_hi",   64'(bus.hi),   64'h0);
    check("rst_mid_lo",   64'(bus.lo),   64'h0);
    check("rst_mid_busy", 64'(bus.busy), 64'h0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_after_busy", 64'(bus.busy), 64'h0);

    repeat (2) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
